// File: rtl/vdma_rd_pkg.sv
// Shared definitions for the VDMA DDR read controller.
//   ADDR_W         : width of the DDR byte address driven to the read master
//   LEN_W          : width of the burst length field (beats minus one)
//   BYTES_PER_BEAT : bytes per beat at the default 64-bit data width
//   state_t        : read sequencer states
package vdma_rd_pkg;

    localparam int unsigned ADDR_W         = 38;
    localparam int unsigned LEN_W          = 8;
    localparam int unsigned DEFAULT_OP_DW  = 64;
    localparam int unsigned BYTES_PER_BEAT = DEFAULT_OP_DW / 8;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT_SPACE,
        REQ,
        WAIT_DONE,
        DONE
    } state_t;

    // Byte stride of one beat for a given data width.
    function automatic int unsigned bytes_per_beat(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ddr_read_controller_vdma.sv
// VDMA DDR read controller.
// Fetches one stored frame from DDR as a series of bursts of up to
// g_BURST_LEN beats. Each burst is issued only once the downstream FIFO
// has room for all of its beats. Only one burst is outstanding at a time.
// A one-cycle int_dma_o pulse marks the end of the frame.
//
// Build option: VDMA_RD_CONTINUOUS_EN
//   When defined, the frame repeats forever from the shadow address with
//   the last frame size. Reset is the only way out of this loop.
//
// Ports:
//   ddr_clk_i              : clock
//   ddr_clk_rst_i          : synchronous active-high reset
//   frame_start_i          : one-cycle pulse that starts a frame (ignored while busy)
//   frame_ddr_addr_valid_i : loads frame_ddr_addr_i into the shadow base address
//   frame_ddr_addr_i       : frame base byte address
//   frame_size_i           : frame length in beats, sampled with frame_start_i
//   fifo_wcount_i          : downstream FIFO fill level, in beats
//   read_ackn_i            : read master accepted the request
//   read_done_i            : all beats of the current burst were delivered
//   read_req_o             : burst request, held until acknowledged
//   read_length_o          : burst beats minus one
//   read_start_addr_o      : burst byte address
//   busy_o                 : frame in progress
//   int_dma_o              : one-cycle frame-complete pulse
module ddr_read_controller_vdma
    import vdma_rd_pkg::*;
#(
    parameter int unsigned g_OP_DW       = 64,
    parameter int unsigned g_FIFO_AWIDTH = 12,
    parameter int unsigned g_BURST_LEN   = 128
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_clk_rst_i,
    input  logic                     frame_start_i,
    input  logic                     frame_ddr_addr_valid_i,
    input  logic [31:0]              frame_ddr_addr_i,
    input  logic [31:0]              frame_size_i,
    input  logic [g_FIFO_AWIDTH-1:0] fifo_wcount_i,
    input  logic                     read_ackn_i,
    input  logic                     read_done_i,
    output logic                     read_req_o,
    output logic [LEN_W-1:0]         read_length_o,
    output logic [ADDR_W-1:0]        read_start_addr_o,
    output logic                     busy_o,
    output logic                     int_dma_o
);

    localparam int unsigned BEAT_BYTES = bytes_per_beat(g_OP_DW);

    state_t              state;
    logic [31:0]         shadow_addr;
    logic [ADDR_W-1:0]   work_addr;
    logic [31:0]         remaining;
    logic [8:0]          burst;
`ifdef VDMA_RD_CONTINUOUS_EN
    logic [31:0]         last_size;
`endif

    logic [8:0]               burst_next;
    logic [g_FIFO_AWIDTH-1:0] fifo_free;
    logic                     space_ok;

    // Burst size and downstream free space; one FIFO slot is kept in reserve
    // so that a completely full FIFO never has to be distinguished from empty.
    always_comb begin
        burst_next = (remaining < 32'(g_BURST_LEN)) ? remaining[8:0] : 9'(g_BURST_LEN);
        fifo_free  = '1 - fifo_wcount_i;
        space_ok   = 32'(fifo_free) >= 32'(burst);
    end

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_clk_rst_i) begin
            state             <= IDLE;
            shadow_addr       <= '0;
            work_addr         <= '0;
            remaining         <= '0;
            burst             <= '0;
            read_req_o        <= 1'b0;
            read_length_o     <= '0;
            read_start_addr_o <= '0;
            busy_o            <= 1'b0;
            int_dma_o         <= 1'b0;
`ifdef VDMA_RD_CONTINUOUS_EN
            last_size         <= '0;
`endif
        end else begin
            if (frame_ddr_addr_valid_i) begin
                shadow_addr <= frame_ddr_addr_i;
            end
            int_dma_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        // An address arriving with the start pulse applies to this frame.
                        work_addr <= ADDR_W'(frame_ddr_addr_valid_i ? frame_ddr_addr_i
                                                                    : shadow_addr);
                        remaining <= frame_size_i;
`ifdef VDMA_RD_CONTINUOUS_EN
                        last_size <= frame_size_i;
`endif
                        busy_o    <= 1'b1;
                        state     <= CALC;
                    end
                end

                CALC: begin
                    burst <= burst_next;
                    state <= (remaining == '0) ? DONE : WAIT_SPACE;
                end

                WAIT_SPACE: begin
                    if (space_ok) begin
                        read_req_o        <= 1'b1;
                        read_length_o     <= LEN_W'(burst - 9'd1);
                        read_start_addr_o <= work_addr;
                        state             <= REQ;
                    end
                end

                REQ: begin
                    if (read_ackn_i) begin
                        read_req_o <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (read_done_i) begin
                        work_addr <= work_addr + ADDR_W'(burst) * ADDR_W'(BEAT_BYTES);
                        remaining <= remaining - 32'(burst);
                        state     <= CALC;
                    end
                end

                DONE: begin
                    int_dma_o <= 1'b1;
`ifdef VDMA_RD_CONTINUOUS_EN
                    work_addr <= ADDR_W'(shadow_addr);
                    remaining <= last_size;
                    state     <= CALC;
`else
                    busy_o    <= 1'b0;
                    state     <= IDLE;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_controller_vdma.sv
module tb_ddr_read_controller_vdma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start_i = 1'b0;
    logic        frame_ddr_addr_valid_i = 1'b0;
    logic [31:0] frame_ddr_addr_i = '0;
    logic [31:0] frame_size_i = '0;
    logic [11:0] fifo_wcount_i = '0;
    logic        read_ackn_i = 1'b0;
    logic        read_done_i = 1'b0;
    logic        read_req_o;
    logic [7:0]  read_length_o;
    logic [37:0] read_start_addr_o;
    logic        busy_o;
    logic        int_dma_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr_read_controller_vdma #(
        .g_OP_DW      (64),
        .g_FIFO_AWIDTH(12),
        .g_BURST_LEN  (128)
    ) dut (
        .ddr_clk_i             (clk),
        .ddr_clk_rst_i         (rst),
        .frame_start_i         (frame_start_i),
        .frame_ddr_addr_valid_i(frame_ddr_addr_valid_i),
        .frame_ddr_addr_i      (frame_ddr_addr_i),
        .frame_size_i          (frame_size_i),
        .fifo_wcount_i         (fifo_wcount_i),
        .read_ackn_i           (read_ackn_i),
        .read_done_i           (read_done_i),
        .read_req_o            (read_req_o),
        .read_length_o         (read_length_o),
        .read_start_addr_o     (read_start_addr_o),
        .busy_o                (busy_o),
        .int_dma_o             (int_dma_o)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] size, input logic load, input logic [31:0] addr);
        frame_start_i = 1'b1;
        frame_size_i  = size;
        if (load) begin
            frame_ddr_addr_valid_i = 1'b1;
            frame_ddr_addr_i       = addr;
        end
        step();
        frame_start_i          = 1'b0;
        frame_ddr_addr_valid_i = 1'b0;
    endtask

    // Wait for a request, check it, hold it for ack_delay cycles, ack, then complete it.
    task automatic serve_burst(input logic [7:0] exp_len, input logic [37:0] exp_addr,
                               input int ack_delay);
        int n = 0;
        while (read_req_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (read_req_o !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout got=%b exp=1", read_req_o);
            return;
        end
        checks++;
        if (read_length_o !== exp_len) begin
            failures++;
            $display("FAIL burst_len got=%0d exp=%0d", read_length_o, exp_len);
        end
        checks++;
        if (read_start_addr_o !== exp_addr) begin
            failures++;
            $display("FAIL burst_addr got=%h exp=%h", read_start_addr_o, exp_addr);
        end
        for (int i = 0; i < ack_delay; i++) begin
            step();
            checks++;
            if ({read_req_o, read_length_o, read_start_addr_o} !== {1'b1, exp_len, exp_addr}) begin
                failures++;
                $display("FAIL req_hold cycle=%0d got=%b/%0d/%h exp=1/%0d/%h", i,
                         read_req_o, read_length_o, read_start_addr_o, exp_len, exp_addr);
            end
        end
        read_ackn_i = 1'b1;
        step();
        read_ackn_i = 1'b0;
        checks++;
        if (read_req_o !== 1'b0) begin
            failures++;
            $display("FAIL req_drop got=%b exp=0", read_req_o);
        end
        step();
        read_done_i = 1'b1;
        step();
        read_done_i = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int n = 0;
        while (int_dma_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (int_dma_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_int got=%b exp=1", name, int_dma_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_end got=%b exp=0", name, busy_o);
        end
        step();
        checks++;
        if (int_dma_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_int_width got=%b exp=0", name, int_dma_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({read_req_o, read_length_o, read_start_addr_o, busy_o, int_dma_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%0d/%h/%b/%b exp=all0",
                     read_req_o, read_length_o, read_start_addr_o, busy_o, int_dma_o);
        end
    endtask

    task automatic test_multi_burst();
        // Stray handshakes in IDLE are ignored.
        read_ackn_i = 1'b1;
        read_done_i = 1'b1;
        frame_ddr_addr_valid_i = 1'b1;
        frame_ddr_addr_i       = 32'h1000_0000;
        step();
        read_ackn_i = 1'b0;
        read_done_i = 1'b0;
        frame_ddr_addr_valid_i = 1'b0;
        start_frame(32'd300, 1'b0, '0);
        checks++;
        if (busy_o !== 1'b1 || read_req_o !== 1'b0) begin
            failures++;
            $display("FAIL mb_cycle1 got=busy%b/req%b exp=busy1/req0", busy_o, read_req_o);
        end
        step();
        checks++;
        if (read_req_o !== 1'b0) begin
            failures++;
            $display("FAIL mb_cycle2 got=%b exp=0", read_req_o);
        end
        step();
        checks++;
        if (read_req_o !== 1'b1) begin
            failures++;
            $display("FAIL mb_latency3 got=%b exp=1", read_req_o);
        end
        serve_burst(8'd127, 38'h10000000, 2);
        serve_burst(8'd127, 38'h10000400, 2);
        serve_burst(8'd43,  38'h10000800, 2);
        // done sampled -> CALC -> DONE -> IDLE with the pulse
        checks++;
        if (int_dma_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL mb_after_done got=int%b/busy%b exp=int0/busy1", int_dma_o, busy_o);
        end
        step();
        checks++;
        if (int_dma_o !== 1'b0) begin
            failures++;
            $display("FAIL mb_early_int got=%b exp=0", int_dma_o);
        end
        step();
        checks++;
        if (int_dma_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL mb_int got=int%b/busy%b exp=int1/busy0", int_dma_o, busy_o);
        end
        step();
        checks++;
        if (int_dma_o !== 1'b0) begin
            failures++;
            $display("FAIL mb_int_once got=%b exp=0", int_dma_o);
        end
    endtask

    task automatic test_backpressure();
        logic seen;
        fifo_wcount_i = 12'd4000;
        start_frame(32'd128, 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            // Stray handshakes while waiting for space are ignored.
            read_ackn_i = (i == 4);
            read_done_i = (i == 5);
            step();
            if (read_req_o !== 1'b0) seen = 1'b1;
        end
        read_ackn_i = 1'b0;
        read_done_i = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_req got=%b exp=0", seen);
        end
        fifo_wcount_i = 12'd3967;
        step();
        checks++;
        if (read_req_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=%b exp=1", read_req_o);
        end
        fifo_wcount_i = '0;
        serve_burst(8'd127, 38'h10000000, 2);
        finish_frame("bp");
    endtask

    task automatic test_delayed_ack();
        start_frame(32'd64, 1'b0, '0);
        serve_burst(8'd63, 38'h10000000, 5);
        finish_frame("dack");
    endtask

    task automatic test_zero_size();
        logic req_seen;
        start_frame(32'd0, 1'b0, '0);
        req_seen = read_req_o;
        checks++;
        if (int_dma_o !== 1'b0) begin
            failures++;
            $display("FAIL zs_int1 got=%b exp=0", int_dma_o);
        end
        // Second start while busy must be ignored.
        start_frame(32'd5, 1'b0, '0);
        req_seen = req_seen | read_req_o;
        checks++;
        if (int_dma_o !== 1'b0) begin
            failures++;
            $display("FAIL zs_int2 got=%b exp=0", int_dma_o);
        end
        step();
        checks++;
        if (int_dma_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL zs_int3 got=int%b/busy%b exp=int1/busy0", int_dma_o, busy_o);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            req_seen = req_seen | read_req_o | busy_o;
        end
        checks++;
        if (req_seen !== 1'b0) begin
            failures++;
            $display("FAIL zs_ignored_start got=%b exp=0", req_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        start_frame(32'd300, 1'b0, '0);
        while (read_req_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        read_ackn_i = 1'b1;
        step();
        read_ackn_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({read_req_o, read_length_o, read_start_addr_o, busy_o, int_dma_o} !== '0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%0d/%h/%b/%b exp=all0",
                     read_req_o, read_length_o, read_start_addr_o, busy_o, int_dma_o);
        end
        // Shadow address was cleared by reset.
        start_frame(32'd8, 1'b0, '0);
        serve_burst(8'd7, 38'h0, 2);
        finish_frame("rst_a");
        // Address presented with the start pulse applies to that frame.
        start_frame(32'd16, 1'b1, 32'h3000_0000);
        serve_burst(8'd15, 38'h30000000, 2);
        finish_frame("rst_b");
    endtask

    task automatic test_addr_update();
        start_frame(32'd200, 1'b0, '0);
        frame_ddr_addr_valid_i = 1'b1;
        frame_ddr_addr_i       = 32'h2000_0000;
        step();
        frame_ddr_addr_valid_i = 1'b0;
        serve_burst(8'd127, 38'h30000000, 2);
        serve_burst(8'd71,  38'h30000400, 2);
        finish_frame("au_a");
        start_frame(32'd8, 1'b0, '0);
        serve_burst(8'd7, 38'h20000000, 2);
        finish_frame("au_b");
    endtask

    initial begin
        test_reset();
        test_multi_burst();
        test_backpressure();
        test_delayed_ack();
        test_zero_size();
        test_reset_mid_frame();
        test_addr_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
